timebase_gen: RTL and testbench

Parametrised multi-channel timebase for the ALU/calculator platform. A shared prescaler divides `clk` into a base tick; `NCH` independently programmable channel dividers derive slower periodic ticks from it, and an uptime counter counts base ticks. It supersedes single-rate 1 ms tick generators and feeds display scanning, key debouncing and calculator timing from one block.

---
 rtl/timebase_pkg.sv | 13 +
 rtl/timebase_gen_chan_div.sv | 44 ++++
 rtl/timebase_gen.sv | 75 +++++++
 tb/tb_timebase_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared constants and helpers for the multi-channel timebase.
package timebase_pkg;

  localparam int unsigned DEF_PRESCALE = 50000;
  localparam int unsigned DEF_DIV_W    = 10;
  localparam int unsigned DEF_CNT_W    = 26;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timebase_gen_chan_div.sv
// One channel divider: divide register, base-tick count and registered tick.
module tb_chan_div #(
  parameter int unsigned DIV_W    = 10,
  parameter int unsigned DIV_INIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             b,
  input  logic             we,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, cnt_q;
  logic             tick_q;
  logic             wrap;

  assign wrap = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q  <= DIV_W'(DIV_INIT);
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (we) begin
      // A write restarts the channel and suppresses any coincident wrap.
      div_q  <= div;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (b && (div_q != '0)) begin
      cnt_q  <= wrap ? '0 : cnt_q + DIV_W'(1);
      tick_q <= wrap;
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/timebase_gen.sv
// Multi-channel timebase: shared prescaler, NCH channel dividers, uptime counter.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned PRE_W    = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned DIV_W    = DEF_DIV_W,
  parameter int unsigned DIV_INIT = 1,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned CH_W    = idx_w(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             base_tick,
  output logic [NCH-1:0]   ch_tick,
  output logic [CNT_W-1:0] uptime,
  output logic             uptime_wrap
);

  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] uptime_q;
  logic             base_tick_q, wrap_q;
  logic             b, wr_ok;

  always_comb begin
    b     = en && !clr && (pre_q == PRE_W'(PRESCALE - 1));
    wr_ok = cfg_we && !clr && (32'(cfg_ch) < NCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q       <= '0;
      uptime_q    <= '0;
      base_tick_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else if (clr) begin
      pre_q       <= '0;
      uptime_q    <= '0;
      base_tick_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      // Prescaler holds its phase while disabled.
      if (en) pre_q <= b ? '0 : pre_q + PRE_W'(1);
      if (b) uptime_q <= uptime_q + CNT_W'(1);
      base_tick_q <= b;
      wrap_q      <= b && (&uptime_q);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tb_chan_div #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .b     (b),
      .we    (wr_ok && (cfg_ch == CH_W'(i))),
      .div   (cfg_div),
      .tick  (ch_tick[i])
    );
  end

  assign base_tick   = base_tick_q;
  assign uptime      = uptime_q;
  assign uptime_wrap = wrap_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Randomized scoreboard bench for timebase_gen against an arithmetic reference model.
module tb_timebase_gen;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned NCH      = 5;
  localparam int unsigned DIV_W    = 10;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CH_W     = 3;

  logic             clk = 1'b0;
  logic             reset, en, clr, cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             base_tick, uptime_wrap;
  logic [NCH-1:0]   ch_tick;
  logic [CNT_W-1:0] uptime;

  timebase_gen #(
    .PRESCALE (PRESCALE),
    .PRE_W    (4),
    .NCH      (NCH),
    .DIV_W    (DIV_W),
    .DIV_INIT (1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clr         (clr),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .base_tick   (base_tick),
    .ch_tick     (ch_tick),
    .uptime      (uptime),
    .uptime_wrap (uptime_wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] ticks;
    int             up;
    bit             wrap;
  } exp_t;
  exp_t q[$];

  // Reference state: enabled cycles into the current base period, base ticks
  // since the last channel write, and the programmed divide values.
  int phase = 0;
  int up    = 0;
  int mdiv[NCH];
  int since[NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Model: evaluated on each clock edge from the inputs the DUT also sees.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        phase = 0;
        up    = 0;
        for (int i = 0; i < NCH; i++) begin
          mdiv[i]  = 1;
          since[i] = 0;
        end
      end else if (clr) begin
        phase = 0;
        up    = 0;
        for (int i = 0; i < NCH; i++) since[i] = 0;
      end else begin
        bit b;
        logic [NCH-1:0] t;
        b = en && (phase == PRESCALE - 1);
        if (en) phase = b ? 0 : phase + 1;
        t = '0;
        if (b) begin
          up = (up + 1) % (1 << CNT_W);
          for (int i = 0; i < NCH; i++) begin
            if (!(cfg_we && int'(cfg_ch) == i) && mdiv[i] != 0) begin
              since[i]++;
              if (since[i] % mdiv[i] == 0) t[i] = 1'b1;
            end
          end
          q.push_back('{cyc: cyc, ticks: t, up: up, wrap: (up == 0)});
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
          mdiv[cfg_ch]  = int'(cfg_div);
          since[cfg_ch] = 0;
        end
      end
    end
  end

  // Monitor: consumes one expected record per observed base tick.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (base_tick === 1'b1) begin
          if (q.size() == 0) begin
            chk("spurious_base_tick", 32'(base_tick), 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("base_tick_cycle", cyc, e.cyc);
            chk("ch_tick", 32'(ch_tick), 32'(e.ticks));
            chk("uptime_wrap", 32'(uptime_wrap), 32'(e.wrap));
          end
        end else begin
          if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("missed_base_tick", 32'(base_tick), 32'd1);
          end
          chk("idle_ch_tick", 32'(ch_tick), 32'd0);
          chk("idle_wrap", 32'(uptime_wrap), 32'd0);
        end
        chk("uptime", 32'(uptime), up);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(d);
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; en = 1'b1; clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    idle(2);
    mon_on = 1'b1;
    chk("reset_base_tick", 32'(base_tick), 32'd0);
    chk("reset_ch_tick", 32'(ch_tick), 32'd0);
    chk("reset_uptime", 32'(uptime), 32'd0);

    // Timing after reset release.
    reset = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (base_tick !== 1'b1 && n < 10);
    chk("first_tick_after_release", n, 4);
    idle(10);

    // Channel periods, including an out-of-range write.
    wr(0, 3); wr(1, 0); wr(2, 2); wr(3, 5);
    wr(5, 7);
    idle(80);

    // Write landing exactly on a due wrap of channel 0.
    n = 0;
    while (!(en && phase == PRESCALE - 1 && mdiv[0] != 0 &&
             (since[0] + 1) % mdiv[0] == 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("collision_found", 32'(n < 200), 32'd1);
    wr(0, 2);
    chk("collision_base_tick", 32'(base_tick), 32'd1);
    chk("collision_no_tick0", 32'(ch_tick[0]), 32'd0);
    idle(30);

    // Enable drop mid-period, then clear.
    n = 0;
    while (phase != 1 && n < 10) begin @(negedge clk); n++; end
    en = 1'b0; idle(7); en = 1'b1;
    idle(20);
    clr = 1'b1; idle(1); clr = 1'b0;
    idle(30);

    // Uptime wrap over many base ticks.
    idle(40 * PRESCALE);

    // Reset together with clear and a write, mid-period.
    n = 0;
    while (phase != 2 && n < 10) begin @(negedge clk); n++; end
    reset = 1'b0; clr = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 10'd9;
    idle(2);
    chk("prio_base_tick", 32'(base_tick), 32'd0);
    chk("prio_ch_tick", 32'(ch_tick), 32'd0);
    chk("prio_uptime", 32'(uptime), 32'd0);
    reset = 1'b1; clr = 1'b0; cfg_we = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (base_tick !== 1'b1 && n < 10);
    chk("first_tick_after_prio_reset", n, 4);
    chk("prio_div_init_tick", 32'(ch_tick), 32'h1f);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      en     = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 49) == 0);
      reset  = ($urandom_range(0, 99) != 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = CH_W'($urandom_range(0, 7));
      cfg_div = DIV_W'($urandom_range(0, 5));
      @(negedge clk);
    end
    reset = 1'b1; en = 1'b1; clr = 1'b0; cfg_we = 1'b0;
    idle(4);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
